// File: rtl/sync_rx_pkg.sv
// Shared definitions for the CDC receive checker: readout selects, default
// error-counter width and the Gray-to-binary decoder.
package sync_rx_pkg;

    localparam int ERR_W_DEFAULT = 8;

    localparam logic [1:0] SEL_ERR     = 2'd0;
    localparam logic [1:0] SEL_STEP_LO = 2'd1;
    localparam logic [1:0] SEL_STEP_HI = 2'd2;
    localparam logic [1:0] SEL_STATUS  = 2'd3;

    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_rx_checker_bit_sync.sv
// Single-bit synchronizer: SYNC_STAGES flops in series, async active-low reset.
module bit_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/sync_rx_checker.sv
// Receive-end CDC checker: synchronizes a foreign 4-bit count, classifies each
// captured word as hold / legal step / illegal jump and exposes counters.
module sync_rx_checker
    import sync_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ERR_W       = ERR_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       clr,
    input  logic       gray_en,
    input  logic [3:0] data_in,
    input  logic [1:0] sel,
    output logic [7:0] result,
    output logic       err_pulse
);

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    logic [3:0]       cur_raw;
    logic [3:0]       cur;
    logic [3:0]       prev;
    logic [3:0]       delta;
    logic             gray_en_q;
    logic             armed;
    logic             mode_stable;
    logic             classify;
    logic             is_step;
    logic             is_jump;
    logic [15:0]      step_cnt;
    logic [ERR_W-1:0] err_cnt;
    logic [7:0]       step_hi_shadow;

    for (genvar i = 0; i < 4; i++) begin : g_sync
        bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bit_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (data_in[i]),
            .q     (cur_raw[i])
        );
    end

    // Classification is also suppressed on the very edge gray_en changes, since
    // prev was decoded under the old mode and cur under the new one.
    always_comb begin
        cur         = gray_en ? gray2bin(cur_raw) : cur_raw;
        delta       = cur - prev;
        mode_stable = (gray_en == gray_en_q);
        classify    = armed && ena && mode_stable;
        is_step     = classify && (delta == 4'd1);
        is_jump     = classify && (delta != 4'd0) && (delta != 4'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev      <= '0;
            gray_en_q <= 1'b0;
        end else begin
            prev      <= cur;
            gray_en_q <= gray_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed     <= 1'b0;
            err_pulse <= 1'b0;
            step_cnt  <= '0;
            err_cnt   <= '0;
        end else if (clr) begin
            armed     <= 1'b0;
            err_pulse <= 1'b0;
            step_cnt  <= '0;
            err_cnt   <= '0;
        end else begin
            armed     <= mode_stable;
            err_pulse <= is_jump;
            if (is_step) begin
                step_cnt <= step_cnt + 16'd1;
            end
            if (is_jump && (err_cnt != ERR_MAX)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    // Reading the low step byte snapshots the high byte for a tear-free pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result         <= '0;
            step_hi_shadow <= '0;
        end else begin
            unique case (sel)
                SEL_ERR:     result <= err_cnt[7:0];
                SEL_STEP_LO: result <= step_cnt[7:0];
                SEL_STEP_HI: result <= step_hi_shadow;
                SEL_STATUS:  result <= {cur, 2'b00, gray_en, armed};
                default:     result <= '0;
            endcase
            if (sel == SEL_STEP_LO) begin
                step_hi_shadow <= step_cnt[15:8];
            end
        end
    end

endmodule

// File: tb/tb_sync_rx_checker.sv
// Self-checking bench for sync_rx_checker: directed scenarios plus a random
// walk, compared against a transition-level model of the count source.
module tb_sync_rx_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       clr;
    logic       gray_en;
    logic [3:0] data_in;
    logic [1:0] sel;
    logic [7:0] result;
    logic       err_pulse;

    int          checks = 0;
    int          errors = 0;
    int          pulse_count = 0;
    int          exp_pulses = 0;
    int          exp_err = 0;
    logic [15:0] exp_step = '0;
    logic [7:0]  exp_shadow;
    int          cur_val = 0;
    bit          model_gray = 1'b0;
    bit          model_ena = 1'b1;

    always #5 clk = ~clk;

    sync_rx_checker #(.SYNC_STAGES(2), .ERR_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .clr       (clr),
        .gray_en   (gray_en),
        .data_in   (data_in),
        .sel       (sel),
        .result    (result),
        .err_pulse (err_pulse)
    );

    always @(negedge clk) begin
        if (rst_n === 1'b1 && err_pulse === 1'b1) pulse_count++;
    end

    function automatic int decode(input int v, input bit g);
        if (!g) return v;
        return v ^ (v >> 1) ^ (v >> 2) ^ (v >> 3);
    endfunction

    // Model of one source change: classify old->new in decoded space.
    task automatic model_apply(input int v);
        int d;
        if (model_ena) begin
            d = (decode(v, model_gray) - decode(cur_val, model_gray) + 16) % 16;
            if (d == 1) begin
                exp_step = exp_step + 16'd1;
            end else if (d != 0) begin
                exp_pulses++;
                if (exp_err < 255) exp_err++;
            end
        end
        cur_val = v;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_stimulus(input int v, input int hold);
        data_in = v[3:0];
        model_apply(v);
        repeat (hold) @(negedge clk);
    endtask

    task automatic check_output(input logic [1:0] s, input int expv, input string tag);
        sel = s;
        @(negedge clk);
        check(tag, {8'h00, result}, expv[15:0]);
    endtask

    task automatic read_counters(input string tag);
        idle(3);
        check_output(2'd0, exp_err & 255, {tag, "_err"});
        check_output(2'd1, int'(exp_step[7:0]), {tag, "_step_lo"});
        check_output(2'd2, int'(exp_step[15:8]), {tag, "_step_hi"});
        check({tag, "_pulses"}, pulse_count[15:0], exp_pulses[15:0]);
        sel = 2'd0;
    endtask

    task automatic do_clear();
        idle(3);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        exp_step = '0;
        exp_err  = 0;
        idle(2);
    endtask

    initial begin
        int v;
        int r;
        rst_n   = 1'b0;
        ena     = 1'b1;
        clr     = 1'b0;
        gray_en = 1'b0;
        data_in = 4'd0;
        sel     = 2'd0;
        idle(2);
        check("reset_result", {8'h00, result}, 16'h0000);
        check("reset_err_pulse", {15'd0, err_pulse}, 16'h0000);
        rst_n = 1'b1;
        idle(3);

        // Binary incrementing source, one step per 4 clocks, wrapping 15->0
        for (int i = 1; i <= 64; i++) apply_stimulus(i % 16, 4);
        read_counters("binary_inc");

        // Forced jump 3 -> 9 with exact pulse timing
        apply_stimulus(3, 4);
        do_clear();
        data_in = 4'd9;
        model_apply(9);
        @(negedge clk);
        check("jump_pulse_n0", {15'd0, err_pulse}, 16'h0000);
        @(negedge clk);
        check("jump_pulse_n1", {15'd0, err_pulse}, 16'h0000);
        @(negedge clk);
        check("jump_pulse_n2", {15'd0, err_pulse}, 16'h0001);
        @(negedge clk);
        check("jump_pulse_n3", {15'd0, err_pulse}, 16'h0000);
        check_output(2'd0, 1, "jump_err_read");

        // Gray mode sequence 0,1,3,2,6 then a mode toggle
        apply_stimulus(0, 4);
        do_clear();
        gray_en    = 1'b1;
        model_gray = 1'b1;
        idle(3);
        apply_stimulus(1, 3);
        apply_stimulus(3, 3);
        apply_stimulus(2, 3);
        apply_stimulus(6, 3);
        read_counters("gray_seq");
        gray_en    = 1'b0;
        model_gray = 1'b0;
        idle(4);
        check_output(2'd3, (cur_val << 4) | 1, "gray_toggle_status");
        read_counters("gray_toggle");

        // Error counter saturation
        do_clear();
        for (int i = 0; i < 300; i++) apply_stimulus(cur_val ^ 8, 1);
        read_counters("saturate");

        // clr coincident with a jump's classification edge
        v = cur_val ^ 8;
        data_in = v[3:0];
        cur_val = v;
        idle(2);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_jump_pulse", {15'd0, err_pulse}, 16'h0000);
        exp_step = '0;
        exp_err  = 0;
        idle(2);
        read_counters("clr_jump");

        // Tear-free readout across a high-byte carry
        do_clear();
        for (int i = 0; i < 255; i++) apply_stimulus((cur_val + 1) % 16, 1);
        idle(3);
        exp_shadow = exp_step[15:8];
        check_output(2'd1, int'(exp_step[7:0]), "tear_lo");
        sel = 2'd0;
        apply_stimulus((cur_val + 1) % 16, 1);
        idle(3);
        check_output(2'd2, int'(exp_shadow), "tear_hi_shadow");
        read_counters("tear_after");

        // Random walk with occasional enable changes
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                idle(3);
                ena       = ~ena;
                model_ena = ena;
            end
            r = $urandom_range(0, 9);
            if (r < 5)      v = (cur_val + 1) % 16;
            else if (r < 7) v = cur_val;
            else            v = $urandom_range(0, 15);
            apply_stimulus(v, $urandom_range(1, 3));
            if (i % 40 == 39) read_counters("random");
        end
        idle(3);
        ena       = 1'b1;
        model_ena = 1'b1;
        read_counters("random_end");

        // Async reset between clock edges, mid-transition
        sel = 2'd0;
        data_in = 4'((cur_val + 5) % 16);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_result", {8'h00, result}, 16'h0000);
        check("async_err_pulse", {15'd0, err_pulse}, 16'h0000);
        data_in  = 4'd0;
        cur_val  = 0;
        exp_step = '0;
        exp_err  = 0;
        sel      = 2'd3;
        idle(2);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_unarmed", {8'h00, result}, 16'h0000);
        @(negedge clk);
        check("post_reset_armed", {8'h00, result}, 16'h0001);
        read_counters("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
